// File: rtl/color_frame_tx.sv
// Frames one colour sample as AA 55 R G B ID CHK and hands the bytes to a UART
// transmitter, one byte per serial character period.
module color_frame_tx #(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [7:0] color_r,
    input  logic [7:0] color_g,
    input  logic [7:0] color_b,
    input  logic [7:0] color_id,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       busy,
    output logic       done
);

    // One character on the line: start + 8 data + stop bits.
    localparam int BYTE_CYCLES = 10 * (CLK_FRE / BAUD_RATE);
    localparam int CNT_W       = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_r;
    logic [7:0]       r_g;
    logic [7:0]       r_b;
    logic [7:0]       r_id;
    logic [7:0]       r_chk;
    logic [7:0]       r_po_data;
    logic [7:0]       w_byte;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    always_comb begin
        w_next    = r_state;
        w_idx_nxt = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next    = S_SEND;
                    w_idx_nxt = 3'd0;
                end
            end
            S_SEND: w_next = S_WAIT;
            S_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    if (r_idx == IDX_LAST) begin
                        w_next = S_DONE;
                    end else begin
                        w_next    = S_SEND;
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Byte 0 comes from a constant, so the same-cycle colour latch is not needed here.
    always_comb begin
        w_byte = 8'hAA;
        case (w_idx_nxt)
            3'd0:    w_byte = 8'hAA;
            3'd1:    w_byte = 8'h55;
            3'd2:    w_byte = r_r;
            3'd3:    w_byte = r_g;
            3'd4:    w_byte = r_b;
            3'd5:    w_byte = r_id;
            3'd6:    w_byte = r_chk;
            default: w_byte = 8'hAA;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_r       <= 8'h00;
            r_g       <= 8'h00;
            r_b       <= 8'h00;
            r_id      <= 8'h00;
            r_chk     <= 8'h00;
            r_po_data <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_r   <= color_r;
                r_g   <= color_g;
                r_b   <= color_b;
                r_id  <= color_id;
                r_chk <= color_r + color_g + color_b + color_id;
            end
            // po_data only moves with a flag: the transmitter samples it live while shifting.
            if (w_next == S_SEND) begin
                r_po_data <= w_byte;
                r_idx     <= w_idx_nxt;
            end else if (r_state == S_DONE) begin
                r_idx <= 3'd0;
            end
            if (w_next == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign po_data = r_po_data;
    assign po_flag = (r_state == S_SEND);
    assign busy    = (r_state == S_SEND) || (r_state == S_WAIT);
    assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_color_frame_tx.sv
// Bench for color_frame_tx: scoreboard of expected bytes/cycles plus a serial
// loopback through a small UART transmitter/receiver model.
module tb_color_frame_tx;

    localparam int BC = 100;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] color_r = 8'h00;
    logic [7:0] color_g = 8'h00;
    logic [7:0] color_b = 8'h00;
    logic [7:0] color_id = 8'h00;
    logic [7:0] po_data;
    logic       po_flag;
    logic       busy;
    logic       done;

    exp_t       sb[$];
    int         done_q[$];
    logic [7:0] lb_exp[$];
    int         cyc = 0;
    int         f_start = -1;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] last_data = 8'h00;
    logic       lb_en = 1'b0;
    logic       line = 1'b1;
    exp_t       e;

    color_frame_tx #(.CLK_FRE(100), .BAUD_RATE(10)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .color_r (color_r),
        .color_g (color_g),
        .color_b (color_b),
        .color_id(color_id),
        .po_data (po_data),
        .po_flag (po_flag),
        .busy    (busy),
        .done    (done)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_busy();
        return int'(f_start >= 0 && cyc >= f_start + 1 && cyc <= f_start + 7 * BC);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Called just after a rising edge; start is high for exactly this cycle.
    task automatic send(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic [7:0] id);
        logic [7:0] fr[7];
        logic [7:0] ck;
        ck = r + g + b + id;
        fr = '{8'hAA, 8'h55, r, g, b, id, ck};
        color_r  = r;
        color_g  = g;
        color_b  = b;
        color_id = id;
        start    = 1'b1;
        f_start  = cyc;
        for (int k = 0; k < 7; k++) begin
            sb.push_back('{fr[k], cyc + 1 + k * BC});
            if (lb_en) lb_exp.push_back(fr[k]);
        end
        done_q.push_back(cyc + 1 + 7 * BC);
        tick(1);
        start = 1'b0;
    endtask

    task automatic drained();
        chk("sb_left", sb.size(), 0);
        chk("done_left", done_q.size(), 0);
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            chk("rst_data", int'(po_data), 0);
            chk("rst_flag", int'(po_flag), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
        end else begin
            chk("busy", int'(busy), exp_busy());
            if (po_flag) begin
                chk("flag_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("byte", int'(po_data), int'(e.data));
                    chk("flag_cyc", cyc, e.cyc);
                end
                last_data = po_data;
            end else begin
                chk("hold", int'(po_data), int'(last_data));
            end
            if (done) begin
                chk("done_expected", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) chk("done_cyc", cyc, done_q.pop_front());
            end
        end
    end

    // Transmitter model: data bits are read live from po_data every cycle.
    initial begin : tx_model
        forever begin
            @(negedge sys_clk);
            if (po_flag && !sys_rst) begin
                line = 1'b0;
                repeat (10) @(negedge sys_clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (10) begin
                        line = po_data[b];
                        @(negedge sys_clk);
                    end
                end
                line = 1'b1;
            end
        end
    end

    initial begin : rx_model
        logic [7:0] d;
        logic       s0;
        logic       sp;
        d = 8'h00;
        forever begin
            @(posedge sys_clk);
            if (line == 1'b0) begin
                repeat (5) @(posedge sys_clk);
                s0 = line;
                for (int b = 0; b < 8; b++) begin
                    repeat (10) @(posedge sys_clk);
                    d[b] = line;
                end
                repeat (10) @(posedge sys_clk);
                sp = line;
                if (lb_en) begin
                    chk("lb_start", int'(s0), 0);
                    chk("lb_stop", int'(sp), 1);
                    chk("lb_expected", int'(lb_exp.size() > 0), 1);
                    if (lb_exp.size() > 0) chk("lb_data", int'(d), int'(lb_exp.pop_front()));
                end
            end
        end
    end

    initial begin
        tick(3);
        chk("rst_state_data", int'(po_data), 0);
        sys_rst = 1'b0;
        tick(5);

        // Basic frame with loopback, input hold and two rejected starts.
        lb_en = 1'b1;
        send(8'h12, 8'h34, 8'h56, 8'h03);
        tick(49);
        color_r = 8'h99;
        tick(200);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(450);
        chk("done_cycle_seen", int'(done), 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(60);
        drained();
        chk("lb_left", lb_exp.size(), 0);
        chk("chk_basic", int'(po_data), 8'h9F);
        lb_en = 1'b0;

        // Checksum wraps modulo 256.
        send(8'hFF, 8'hFF, 8'hFF, 8'h05);
        tick(760);
        drained();
        chk("chk_wrap", int'(po_data), 8'h02);

        // Mid-frame reset, then a clean frame afterwards.
        send(8'($urandom_range(0, 255)), 8'h21, 8'h43, 8'h65);
        tick(349);
        sys_rst = 1'b1;
        sb.delete();
        done_q.delete();
        f_start   = -1;
        last_data = 8'h00;
        #1;
        chk("async_rst_data", int'(po_data), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_flag", int'(po_flag), 0);
        tick(3);
        sys_rst = 1'b0;
        tick(200);
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h80, 8'h7F);
        tick(760);
        drained();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
